// File: rtl/cnn_weight_store.sv
// Runtime-loadable CNN weight store: byte-stream load port fills a flop array,
// burst read port with valid/ready and pass replay feeds the MAC sequencer.
module cnn_weight_store #(
  parameter int WEIGHT_W = 8,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int REP_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_start,
  input  logic [ADDR_W-1:0]   ld_base,
  input  logic [ADDR_W:0]     ld_len,
  input  logic                ld_valid,
  input  logic [WEIGHT_W-1:0] ld_data,
  output logic                ld_ready,
  output logic                ld_done,
  output logic                ld_err,
  output logic [15:0]         ld_sum,
  input  logic                rd_start,
  input  logic [ADDR_W-1:0]   rd_base,
  input  logic [ADDR_W:0]     rd_len,
  input  logic [REP_W-1:0]    rd_rep,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [WEIGHT_W-1:0] rd_data,
  output logic                rd_last,
  output logic                rd_busy
);

  typedef enum logic {LD_IDLE, LD_LOAD} ld_state_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [REP_W-1:0]  REP_ONE  = 1;

  logic [WEIGHT_W-1:0] mem_q [DEPTH];

  ld_state_t           ld_state_q, ld_state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     ld_rem_q, ld_rem_d;
  logic [15:0]         ld_sum_q, ld_sum_d;
  logic                ld_err_q, ld_err_d;
  logic                ld_done_q, ld_done_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WEIGHT_W-1:0] mem_wdata;

  rd_state_t           rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
  logic [ADDR_W:0]     rd_len_q, rd_len_d;
  logic [REP_W-1:0]    rd_rep_q, rd_rep_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W:0]     beat_q, beat_d;
  logic [REP_W-1:0]    pass_q, pass_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [WEIGHT_W-1:0] rd_data_q, rd_data_d;

  logic                fetch;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [ADDR_W:0]     next_beat;
  logic [REP_W-1:0]    next_pass;

  // The write pointer carries an extra MSB so overruns past DEPTH-1 are seen, not wrapped.
  always_comb begin
    ld_state_d = ld_state_q;
    wr_ptr_d   = wr_ptr_q;
    ld_rem_d   = ld_rem_q;
    ld_sum_d   = ld_sum_q;
    ld_err_d   = ld_err_q;
    ld_done_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q[ADDR_W-1:0];
    mem_wdata  = ld_data;
    if (ld_start && ld_len != '0) begin
      ld_state_d = LD_LOAD;
      wr_ptr_d   = {1'b0, ld_base};
      ld_rem_d   = ld_len;
      ld_sum_d   = '0;
      ld_err_d   = 1'b0;
    end else if (ld_state_q == LD_LOAD && ld_valid) begin
      if (!wr_ptr_q[ADDR_W]) begin
        mem_we   = 1'b1;
        ld_sum_d = ld_sum_q + 16'(ld_data);
      end else begin
        ld_err_d = 1'b1;
      end
      wr_ptr_d = wr_ptr_q + CNT_ONE;
      ld_rem_d = ld_rem_q - CNT_ONE;
      if (ld_rem_q == CNT_ONE) begin
        ld_state_d = LD_IDLE;
        ld_done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q <= LD_IDLE;
      wr_ptr_q   <= '0;
      ld_rem_q   <= '0;
      ld_sum_q   <= '0;
      ld_err_q   <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      wr_ptr_q   <= wr_ptr_d;
      ld_rem_q   <= ld_rem_d;
      ld_sum_q   <= ld_sum_d;
      ld_err_q   <= ld_err_d;
      ld_done_q  <= ld_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // A fetch reads the array before this edge's write lands, so same-cycle collisions return old data.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_base_d  = rd_base_q;
    rd_len_d   = rd_len_q;
    rd_rep_d   = rd_rep_q;
    raddr_d    = raddr_q;
    beat_d     = beat_q;
    pass_d     = pass_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    fetch      = 1'b0;
    fetch_addr = raddr_q;
    next_beat  = beat_q + CNT_ONE;
    next_pass  = pass_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (rd_start && rd_len != '0) begin
          rd_state_d = RD_STREAM;
          rd_base_d  = rd_base;
          rd_len_d   = rd_len;
          rd_rep_d   = rd_rep;
          fetch      = 1'b1;
          fetch_addr = rd_base;
          next_beat  = CNT_ONE;
          next_pass  = '0;
        end
      end
      RD_STREAM: begin
        if (rd_valid_q && rd_ready) begin
          if (rd_last_q) begin
            rd_state_d = RD_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else begin
            fetch = 1'b1;
            if (beat_q == rd_len_q) begin
              fetch_addr = rd_base_q;
              next_beat  = CNT_ONE;
              next_pass  = pass_q + REP_ONE;
            end
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (fetch) begin
      rd_data_d  = mem_q[fetch_addr];
      rd_valid_d = 1'b1;
      rd_last_d  = (next_beat == rd_len_d) && (next_pass == rd_rep_d);
      raddr_d    = fetch_addr + ADDR_ONE;
      beat_d     = next_beat;
      pass_d     = next_pass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_base_q  <= '0;
      rd_len_q   <= '0;
      rd_rep_q   <= '0;
      raddr_q    <= '0;
      beat_q     <= '0;
      pass_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_base_q  <= rd_base_d;
      rd_len_q   <= rd_len_d;
      rd_rep_q   <= rd_rep_d;
      raddr_q    <= raddr_d;
      beat_q     <= beat_d;
      pass_q     <= pass_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ld_ready = (ld_state_q == LD_LOAD);
  assign ld_done  = ld_done_q;
  assign ld_err   = ld_err_q;
  assign ld_sum   = ld_sum_q;
  assign rd_busy  = (rd_state_q == RD_STREAM);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_cnn_weight_store.sv
// Scoreboard bench for cnn_weight_store: a reference memory predicts every read beat,
// a negedge monitor pops and compares each accepted beat.
module tb_cnn_weight_store;
  localparam int WEIGHT_W = 8;
  localparam int DEPTH    = 256;
  localparam int ADDR_W   = 8;
  localparam int REP_W    = 4;

  logic                clk;
  logic                rst_n;
  logic                ld_start;
  logic [ADDR_W-1:0]   ld_base;
  logic [ADDR_W:0]     ld_len;
  logic                ld_valid;
  logic [WEIGHT_W-1:0] ld_data;
  logic                ld_ready;
  logic                ld_done;
  logic                ld_err;
  logic [15:0]         ld_sum;
  logic                rd_start;
  logic [ADDR_W-1:0]   rd_base;
  logic [ADDR_W:0]     rd_len;
  logic [REP_W-1:0]    rd_rep;
  logic                rd_ready;
  logic                rd_valid;
  logic [WEIGHT_W-1:0] rd_data;
  logic                rd_last;
  logic                rd_busy;

  cnn_weight_store #(
    .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .REP_W(REP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_err(ld_err), .ld_sum(ld_sum),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_rep(rd_rep),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_busy(rd_busy)
  );

  logic [WEIGHT_W-1:0] ref_mem [DEPTH];
  logic [WEIGHT_W-1:0] sb_data [$];
  logic                sb_last [$];
  logic [WEIGHT_W-1:0] ld_vec  [16];
  logic [WEIGHT_W-1:0] exp_d;
  logic                exp_l;
  int n_checks   = 0;
  int n_fail     = 0;
  int beats_seen = 0;
  int b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every accepted beat is matched against the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      beats_seen++;
      if (sb_data.size() == 0) begin
        checkOutput("beat_predicted", 32'(sb_data.size()), 1);
      end else begin
        exp_d = sb_data.pop_front();
        exp_l = sb_last.pop_front();
        checkOutput("rd_data", 32'(rd_data), 32'(exp_d));
        checkOutput("rd_last", 32'(rd_last), 32'(exp_l));
      end
    end
  end

  task automatic pushExpected(input int base, input int len, input int rep);
    for (int p = 0; p <= rep; p++)
      for (int i = 0; i < len; i++) begin
        sb_data.push_back(ref_mem[(base + i) % DEPTH]);
        sb_last.push_back(p == rep && i == len - 1);
      end
  endtask

  task automatic applyLoad(input int base, input int len);
    @(posedge clk); #1;
    ld_start = 1'b1;
    ld_base  = ADDR_W'(base);
    ld_len   = (ADDR_W+1)'(len);
    @(posedge clk); #1;
    ld_start = 1'b0;
    checkOutput("ld_ready_rise", 32'(ld_ready), 1);
    for (int i = 0; i < len; i++) begin
      ld_valid = 1'b1;
      ld_data  = ld_vec[i];
      if (base + i < DEPTH) ref_mem[base + i] = ld_vec[i];
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    checkOutput("ld_done", 32'(ld_done), 1);
    checkOutput("ld_ready_fall", 32'(ld_ready), 0);
    @(posedge clk); #1;
    checkOutput("ld_done_pulse", 32'(ld_done), 0);
  endtask

  task automatic waitReadDone();
    int cyc = 0;
    while (sb_data.size() != 0 && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput("read_drained", 32'(sb_data.size()), 0);
    #1;
    checkOutput("rd_busy_fall", 32'(rd_busy), 0);
    checkOutput("rd_valid_fall", 32'(rd_valid), 0);
    checkOutput("rd_last_fall", 32'(rd_last), 0);
  endtask

  task automatic applyRead(input int base, input int len, input int rep);
    pushExpected(base, len, rep);
    @(posedge clk); #1;
    rd_start = 1'b1;
    rd_base  = ADDR_W'(base);
    rd_len   = (ADDR_W+1)'(len);
    rd_rep   = REP_W'(rep);
    @(posedge clk); #1;
    rd_start = 1'b0;
    checkOutput("rd_busy_rise", 32'(rd_busy), 1);
    checkOutput("rd_valid_rise", 32'(rd_valid), 1);
    waitReadDone();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0;
    ld_data = '0; rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_rep = '0;
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #3;
    checkOutput("rst_ld_ready", 32'(ld_ready), 0);
    checkOutput("rst_ld_done", 32'(ld_done), 0);
    checkOutput("rst_ld_err", 32'(ld_err), 0);
    checkOutput("rst_ld_sum", 32'(ld_sum), 0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 0);
    checkOutput("rst_rd_last", 32'(rd_last), 0);
    checkOutput("rst_rd_busy", 32'(rd_busy), 0);
    checkOutput("rst_rd_data", 32'(rd_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    ld_vec[0] = 8'h05; ld_vec[1] = 8'hFB; ld_vec[2] = 8'h7F; ld_vec[3] = 8'h80;
    applyLoad(0, 4);
    checkOutput("sum_basic", 32'(ld_sum), 32'h01FF);
    checkOutput("err_basic", 32'(ld_err), 0);

    applyRead(0, 4, 1);

    // Backpressure: ready pattern 1,0,0,1 after the first beat appears.
    pushExpected(0, 4, 0);
    b0 = beats_seen;
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = '0; rd_len = 9'd4; rd_rep = '0;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    checkOutput("stall_hold0", 32'(rd_data), 32'(sb_data[0]));
    @(posedge clk); #1;
    checkOutput("stall_hold1", 32'(rd_data), 32'(sb_data[0]));
    checkOutput("stall_last", 32'(rd_last), 0);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    waitReadDone();
    checkOutput("stall_beats", 32'(beats_seen - b0), 4);

    ld_vec[0] = 8'hA1; ld_vec[1] = 8'hA2; ld_vec[2] = 8'hA3; ld_vec[3] = 8'hA4;
    applyLoad(DEPTH - 2, 4);
    checkOutput("sum_overflow", 32'(ld_sum), 32'h0143);
    checkOutput("err_overflow", 32'(ld_err), 1);

    applyRead(DEPTH - 1, 3, 0);

    // Write 0x11 to address 3 on the same edge the stream fetches address 3.
    pushExpected(0, 8, 0);
    sb_last[7] = 1'b0;
    ref_mem[3] = 8'h11;
    pushExpected(0, 8, 0);
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = '0; rd_len = 9'd8; rd_rep = 4'd1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(posedge clk); #1;
    ld_start = 1'b1; ld_base = 8'd3; ld_len = 9'd1;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'h11;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checkOutput("conc_ld_done", 32'(ld_done), 1);
    checkOutput("conc_ld_sum", 32'(ld_sum), 32'h11);
    waitReadDone();

    // Reset in the middle of a read stream and a load burst.
    pushExpected(0, 8, 3);
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base = '0; rd_len = 9'd8; rd_rep = 4'd3;
    @(posedge clk); #1;
    rd_start = 1'b0;
    ld_start = 1'b1; ld_base = 8'd10; ld_len = 9'd5;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 8'h33;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rd_valid", 32'(rd_valid), 0);
    checkOutput("midrst_ld_ready", 32'(ld_ready), 0);
    checkOutput("midrst_rd_busy", 32'(rd_busy), 0);
    checkOutput("midrst_ld_done", 32'(ld_done), 0);
    sb_data.delete();
    sb_last.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ld_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("postrst_ld_sum", 32'(ld_sum), 0);
    applyRead(0, 16, 0);
    applyRead(DEPTH - 3, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_weight_store.md
# cnn_weight_store

Parametrised, runtime-loadable weight memory for the CNN datapath. It replaces hard-coded initial-block weight tables with a register-file store. The store is filled over a byte-stream load port and drained by the MAC engine through a burst read port with valid/ready handshake and burst replay for filter reuse across pixels. It sits between the chip I/O deserialiser (load side) and the conv/dense MAC sequencer (read side).

## Interface
- `WEIGHT_W`, default 8: weight width in bits; stored and returned as signed two's complement.
- `DEPTH`, default 256: number of weight words; power of two, 16..1024.
- `ADDR_W`, default $clog2(DEPTH): address width.
- `REP_W`, default 4: replay-count width.

- `clk` in 1: the block's single clock; everything is sampled on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ld_start` in 1: one-cycle pulse that begins a load burst.
- `ld_base` in ADDR_W: first write address, captured on `ld_start`.
- `ld_len` in ADDR_W+1: number of words to load, captured on `ld_start`.
- `ld_valid` in 1: `ld_data` is valid this cycle.
- `ld_data` in WEIGHT_W: weight word to write.
- `ld_ready` out 1: high while the load FSM is in LOAD.
- `ld_done` out 1: one-cycle pulse after the final word is accepted.
- `ld_err` out 1: sticky overflow flag.
- `ld_sum` out 16: running checksum of accepted words.
- `rd_start` in 1: one-cycle pulse that begins a read burst.
- `rd_base` in ADDR_W: first read address, captured on `rd_start`.
- `rd_len` in ADDR_W+1: number of words per pass, captured on `rd_start`.
- `rd_rep` in REP_W: burst is played `rd_rep`+1 passes; captured on `rd_start`.
- `rd_ready` in 1: consumer accepts `rd_data`.
- `rd_valid` out 1: `rd_data` is valid.
- `rd_data` out WEIGHT_W: signed weight.
- `rd_last` out 1: high on the final beat of the final pass.
- `rd_busy` out 1: read FSM is not in IDLE.

## Operation
- Storage is DEPTH×WEIGHT_W flops. Reset clears every word to 0.
- The load FSM has two states, IDLE and LOAD.
  - `ld_start` with `ld_len`≠0 → LOAD; the write pointer becomes `ld_base`, the remaining count becomes `ld_len`, `ld_sum` and `ld_err` clear.
  - `ld_start` with `ld_len`=0 is ignored.
  - In LOAD, each `ld_valid`&&`ld_ready` consumes one word.
  - If the write pointer ≤ DEPTH−1, the word is written and added to `ld_sum`. `ld_sum` is the sum mod 2^16 of the words zero-extended as unsigned.
  - Otherwise the word is dropped and `ld_err` sets. The write pointer does not wrap.
  - When the remaining count reaches 0 → IDLE, and `ld_done` pulses.
  - `ld_start` during LOAD restarts the burst with the new base and length. `ld_done` does not pulse for the aborted burst.
- The read FSM has two states, IDLE and STREAM.
  - `rd_start` with `rd_len`≠0 → STREAM; `rd_start` with `rd_len`=0 is ignored.
  - `rd_start` is ignored while in STREAM.
  - The read address increments modulo DEPTH, so a burst wraps from DEPTH−1 to 0.
  - After `rd_len` beats, the address reloads `rd_base` and the pass counter increments.
  - After `rd_rep`+1 passes → IDLE.
- Load and read are independent and may run concurrently.
  - If a word is written at the address being fetched in the same cycle, the read returns the old value.
  - A later beat of the same burst returns the new value.

## Timing
- Reset values: `ld_ready`, `ld_done`, `ld_err`, `rd_valid`, `rd_last` and `rd_busy` are 0; `ld_sum` and `rd_data` are 0.
- `ld_ready` is high from the cycle after `ld_start`.
- A word presented with `ld_valid` in cycle t is visible to reads issued from cycle t+1.
- `ld_done` is high in the cycle after the final accepting edge, and `ld_ready` is low in that same cycle.
- Read latency:
  - `rd_start` in cycle t gives `rd_valid` in cycle t+1 with mem[`rd_base`].
  - `rd_busy` rises in cycle t+1.
  - `rd_data` is registered.
- Read throughput is one beat per cycle while `rd_ready` is high.
- Backpressure: while `rd_valid`&&!`rd_ready`, `rd_data` and `rd_last` hold and the address does not advance.
- `rd_valid`, `rd_busy` and `rd_last` drop in the cycle after the final beat is accepted.
- The next `rd_start` is accepted in that cycle, so there is no gap beyond one cycle.
- Reset asserted mid-burst returns both FSMs to IDLE immediately and clears the memory. No `ld_done` is issued.

## Test plan
- Reset, then load base 0, length 4, data 0x05, 0xFB, 0x7F, 0x80 → `ld_done` after the 4th beat, `ld_sum`=0x01FF, `ld_err`=0.
- Read base 0, length 4, `rd_rep`=1 → 8 beats 5, −5, 127, −128, 5, −5, 127, −128; `rd_last` only on beat 8.
- Toggle `rd_ready` 1,0,0,1 during a burst → data holds over the stall, no beat is lost or duplicated, and total beats = length.
- Load base DEPTH−2, length 4 → 2 words written, 2 dropped, `ld_err`=1, and `ld_sum` covers only the 2 written words.
- Read base DEPTH−1, length 3 → the addresses DEPTH−1, 0, 1 are returned in order.
- Concurrent load of 0x11 to address 3 while a read stream passes address 3 in the same cycle → the old value is returned; a following pass returns 0x11.
- `rst_n` low mid-stream → `rd_valid`=0 and `ld_ready`=0 at once; a subsequent read of any address returns 0.
